// File: rtl/sram_access_seq.sv
// LC-3 memory-access sequencer: one MAR/MDR request becomes a SETUP / ACCESS / HOLD SRAM cycle.
// Optional byte lanes: define SRAM_ACCESS_SEQ_BYTE_EN to add the byte_en[1:0] input.
module sram_access_seq #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
    input  logic [1:0]        byte_en,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB
);

    localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_rd;
    logic             accept_rd;

    assign accept_rd = req_rd;

`ifdef SRAM_ACCESS_SEQ_BYTE_EN
    logic [1:0] be_q;
`else
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;
`endif

    // Strobes are registered: each transition loads the levels for the state being entered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_rd    <= 1'b0;
            rdata    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ADDR     <= '0;
            Data_out <= '0;
            Data_oe  <= 1'b0;
            Mem_CE   <= 1'b1;
            Mem_OE   <= 1'b1;
            Mem_WE   <= 1'b1;
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
            be_q     <= '0;
            Mem_UB   <= 1'b0;
            Mem_LB   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        is_rd    <= accept_rd;
                        ADDR     <= addr;
                        Data_out <= wdata;
                        Mem_CE   <= 1'b0;
                        Data_oe  <= ~accept_rd;
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
                        be_q     <= byte_en;
                        Mem_UB   <= accept_rd ? 1'b0 : ~byte_en[1];
                        Mem_LB   <= accept_rd ? 1'b0 : ~byte_en[0];
`endif
                    end
                end
                SETUP: begin
                    state  <= ACCESS;
                    cnt    <= CNT_W'(WAIT_EFF - 1);
                    Mem_OE <= ~is_rd;
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
                    // A write with no lanes enabled keeps full timing but never strobes WE.
                    Mem_WE <= is_rd | ~(|be_q);
`else
                    Mem_WE <= is_rd;
`endif
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        Mem_OE <= 1'b1;
                        Mem_WE <= 1'b1;
                        done   <= 1'b1;
                        if (is_rd) begin
                            rdata <= Data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    Mem_CE  <= 1'b1;
                    Data_oe <= 1'b0;
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
                    Mem_UB  <= 1'b0;
                    Mem_LB  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// Self-checking bench for sram_access_seq: SRAM model, reference memory and directed/random transactions.
module tb_sram_access_seq;

    localparam int unsigned W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_rd, req_wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done, busy;
    logic [19:0] ADDR;
    logic [15:0] Data_out;
    logic        Data_oe;
    logic [15:0] Data_in;
    logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned viol_cnt  = 0;

    logic [15:0] sram    [0:63];
    logic [15:0] ref_mem [0:63];
    logic        wr_pend = 1'b0;

    always #5 Clk = ~Clk;

    sram_access_seq #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata),
`ifdef SRAM_ACCESS_SEQ_BYTE_EN
        .byte_en(2'b11),
`endif
        .rdata(rdata), .done(done), .busy(busy), .ADDR(ADDR),
        .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
    );

    // SRAM model: drives data while selected and output-enabled; a write commits when WE rises with CE still low.
    assign Data_in = (!Mem_CE && !Mem_OE) ? sram[ADDR[5:0]] : 16'h0000;

    always @(negedge Clk) begin
        if (wr_pend && !Mem_CE && Mem_WE && Data_oe)
            sram[ADDR[5:0]] = Data_out;
        wr_pend = !Mem_CE && !Mem_WE;
        if (!Reset) begin
            if (!Mem_OE && !Mem_WE) viol_cnt++;
            if (!Mem_OE && Data_oe) viol_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request from IDLE; expectations come from the reference memory and the latency rules.
    task automatic do_txn(input logic rd, input logic wr, input logic [19:0] a, input logic [15:0] d);
        int unsigned oe_n, we_n, doe_n, done_k;
        logic        busy_ok, addr_ok;
        logic [15:0] exp_rd;
        exp_rd  = ref_mem[a[5:0]];
        req_rd  = rd; req_wr = wr; addr = a; wdata = d;
        @(posedge Clk); #1;
        req_rd  = 1'b0; req_wr = 1'b0;
        addr    = 20'($urandom); wdata = 16'($urandom);
        oe_n = 0; we_n = 0; doe_n = 0; done_k = 0; busy_ok = 1'b1; addr_ok = 1'b1;
        for (int unsigned k = 1; k <= 16 && done_k == 0; k++) begin
            @(negedge Clk);
            if (!Mem_OE)   oe_n++;
            if (!Mem_WE)   we_n++;
            if (Data_oe)   doe_n++;
            if (!busy || Mem_CE) busy_ok = 1'b0;
            if (ADDR !== a) addr_ok = 1'b0;
            if (done)      done_k = k;
        end
        check("done_latency", done_k, W + 2);
        check("oe_low_cycles", oe_n, rd ? W : 0);
        check("we_low_cycles", we_n, (wr && !rd) ? W : 0);
        check("data_oe_cycles", doe_n, (wr && !rd) ? W + 2 : 0);
        check("busy_ce_during", {31'd0, busy_ok}, 32'd1);
        check("addr_held", {31'd0, addr_ok}, 32'd1);
        if (rd) check("rdata", rdata, exp_rd);
        else if (wr) ref_mem[a[5:0]] = d;
        @(negedge Clk);
        check("idle_after", {done, busy, Mem_CE, Data_oe}, 4'b0010);
        check("mem_word", sram[a[5:0]], ref_mem[a[5:0]]);
        if (rd) check("rdata_stable", rdata, exp_rd);
    endtask

    initial begin
        logic [19:0] ra;
        logic [15:0] rdv;
        logic        rr, rw;
        int unsigned dq[$];
        int unsigned we_n, done_n;

        for (int i = 0; i < 64; i++) begin
            sram[i]    = 16'($urandom);
            ref_mem[i] = sram[i];
        end
        sram[6'h12] = 16'hBEEF; ref_mem[6'h12] = 16'hBEEF;

        Reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("rst_strobes", {Mem_CE, Mem_OE, Mem_WE}, 3'b111);
        check("rst_busy_done_oe", {busy, done, Data_oe}, 3'b000);
        check("rst_addr", ADDR, 20'h0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_bytelanes", {Mem_UB, Mem_LB}, 2'b00);

        do_txn(1'b1, 1'b0, 20'h00012, 16'h0000);
        check("beef", rdata, 16'hBEEF);
        do_txn(1'b0, 1'b1, 20'h0003F, 16'h1234);
        check("mem3f", sram[6'h3F], 16'h1234);
        do_txn(1'b1, 1'b1, 20'h00021, 16'hA5A5);

        // Reset lands on the first ACCESS cycle of a write.
        ref_mem[6'h20] = 16'h0F0F; sram[6'h20] = 16'h0F0F;
        req_wr = 1'b1; addr = 20'h00020; wdata = 16'h5555;
        @(posedge Clk); #1; req_wr = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_we_low", {31'd0, Mem_WE}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        check("abort_strobes", {Mem_CE, Mem_OE, Mem_WE}, 3'b111);
        check("abort_state", {busy, done, Data_oe}, 3'b000);
        Reset = 1'b0;
        done_n = 0;
        repeat (6) begin
            @(negedge Clk);
            if (done || busy) done_n++;
        end
        check("abort_no_done", done_n, 0);
        check("abort_mem", sram[6'h20], 16'h0F0F);

        // Back-to-back reads with req_rd held; a stray write pulse must be ignored.
        req_rd = 1'b1; addr = 20'h00012;
        we_n = 0;
        for (int unsigned c = 0; c < 60 && dq.size() < 3; c++) begin
            @(negedge Clk);
            if (c == 2) req_wr = 1'b1;
            if (c == 3) req_wr = 1'b0;
            if (!Mem_WE) we_n++;
            if (done) begin
                dq.push_back(c);
                if (dq.size() == 3) req_rd = 1'b0;
            end
        end
        check("b2b_count", dq.size(), 3);
        if (dq.size() == 3) begin
            check("b2b_spacing1", dq[1] - dq[0], W + 3);
            check("b2b_spacing2", dq[2] - dq[1], W + 3);
        end
        check("b2b_no_write", we_n, 0);
        check("b2b_rdata", rdata, 16'hBEEF);
        repeat (3) @(negedge Clk);
        check("b2b_idle", {busy, Mem_CE}, 2'b01);

        for (int n = 0; n < 20; n++) begin
            ra  = 20'($urandom_range(63));
            rdv = 16'($urandom);
            rr  = 1'($urandom);
            rw  = ~rr | 1'($urandom);
            do_txn(rr, rw, ra, rdv);
        end

        check("protocol_violations", viol_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
